// File: rtl/alu_issue_queue.sv
// Command FIFO, issue register and output register in front of the combinational alu.
// Both handshakes depend only on registered state, never on the ALU path.
module alu_issue_queue #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_a,
   input  logic [DATA_W-1:0]        in_b,
   input  logic [1:0]               in_opcode,
   output logic [DATA_W-1:0]        alu_a,
   output logic [DATA_W-1:0]        alu_b,
   output logic [1:0]               alu_opcode,
   input  logic [DATA_W-1:0]        alu_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_result,
   output logic [1:0]               out_opcode,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 + 2 * DATA_W;

   logic [EW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              iss_valid_q, iss_valid_d;
   logic [DATA_W-1:0] iss_a_q, iss_a_d;
   logic [DATA_W-1:0] iss_b_q, iss_b_d;
   logic [1:0]        iss_op_q, iss_op_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_result_q, out_result_d;
   logic [1:0]        out_opcode_q, out_opcode_d;

   logic              push, pop, out_load;
   logic [EW-1:0]     head;

   always_comb begin
      in_ready = (count_q < CW'(DEPTH));
      push     = in_valid && in_ready;
      out_load = iss_valid_q && (!out_valid_q || out_ready);
      pop      = (count_q != '0) && (!iss_valid_q || out_load);
      head     = mem_q[rd_ptr_q];

      wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d      = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (!push && pop)
         count_d = count_q - CW'(1);

      // ISS data only changes on pop so the ALU inputs hold their last issued values.
      iss_valid_d  = iss_valid_q;
      iss_a_d      = iss_a_q;
      iss_b_d      = iss_b_q;
      iss_op_d     = iss_op_q;
      if (pop) begin
         iss_valid_d = 1'b1;
         iss_op_d    = head[EW-1 -: 2];
         iss_a_d     = head[2*DATA_W-1 -: DATA_W];
         iss_b_d     = head[DATA_W-1:0];
      end else if (out_load) begin
         iss_valid_d = 1'b0;
      end

      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_opcode_d = out_opcode_q;
      if (out_load) begin
         out_valid_d  = 1'b1;
         out_result_d = alu_result;
         out_opcode_d = iss_op_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {in_opcode, in_a, in_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         iss_valid_q  <= 1'b0;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         iss_op_q     <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_opcode_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         iss_valid_q  <= iss_valid_d;
         iss_a_q      <= iss_a_d;
         iss_b_q      <= iss_b_d;
         iss_op_q     <= iss_op_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_opcode_q <= out_opcode_d;
      end
   end

   assign alu_a      = iss_a_q;
   assign alu_b      = iss_b_q;
   assign alu_opcode = iss_op_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_opcode = out_opcode_q;
   assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a small behavioural alu model on the ALU ports.
// Expected results are hand-computed constants in the stimulus tables.
module tb_alu_issue_queue;

   logic       clk;
   logic       rst_n;
   logic       inValid;
   logic       inReady;
   logic [7:0] inA;
   logic [7:0] inB;
   logic [1:0] inOpcode;
   logic [7:0] aluA;
   logic [7:0] aluB;
   logic [1:0] aluOpcode;
   logic [7:0] aluResult;
   logic       outValid;
   logic       outReady;
   logic [7:0] outResult;
   logic [1:0] outOpcode;
   logic [2:0] count;

   int checkCount;
   int errorCount;

   alu_issue_queue #(.DATA_W(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_a       (inA),
      .in_b       (inB),
      .in_opcode  (inOpcode),
      .alu_a      (aluA),
      .alu_b      (aluB),
      .alu_opcode (aluOpcode),
      .alu_result (aluResult),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_result (outResult),
      .out_opcode (outOpcode),
      .count      (count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the alu: ADD, SUB, and arbitrary AND/XOR for the uninterpreted opcodes.
   always_comb begin
      aluResult = 8'h00;
      case (aluOpcode)
         2'b00:   aluResult = aluA + aluB;
         2'b01:   aluResult = aluA - aluB;
         2'b10:   aluResult = aluA & aluB;
         default: aluResult = aluA ^ aluB;
      endcase
   end

   // Compares one observed value against its expected value and tallies the result.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drives one command onto the input handshake.
   task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      inValid  = valid;
      inA      = a;
      inB      = b;
      inOpcode = op;
   endtask

   // Advances one clock and leaves time just past the edge for sampling and driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] b2bA   [4] = '{8'd20, 8'd10, 8'd255, 8'd0};
   logic [7:0] b2bB   [4] = '{8'd7,  8'd5,  8'd1,   8'd1};
   logic [1:0] b2bOp  [4] = '{2'b01, 2'b00, 2'b00,  2'b01};
   logic [7:0] b2bExp [4] = '{8'd13, 8'd15, 8'd0,   8'd255};

   logic [7:0] bpA   [8] = '{8'd1, 8'd9, 8'd200, 8'd3,   8'hF0, 8'hF0, 8'd128, 8'd50};
   logic [7:0] bpB   [8] = '{8'd2, 8'd4, 8'd100, 8'd5,   8'h3C, 8'h3C, 8'd128, 8'd50};
   logic [1:0] bpOp  [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
   logic [7:0] bpExp [8] = '{8'd3, 8'd5, 8'd44,  8'd254, 8'h30, 8'hCC, 8'd0,   8'd0};

   initial begin
      int  idx;
      int  nextOut;
      int  cyc;
      logic accepted;
      logic fire;

      checkCount = 0;
      errorCount = 0;
      rst_n      = 1'b0;
      outReady   = 1'b0;
      applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);

      #2;
      checkOutput("rstOutValid", outValid, 0);
      checkOutput("rstCount", count, 0);
      checkOutput("rstInReady", inReady, 1);
      checkOutput("rstAluA", aluA, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] single ADD");
      outReady = 1'b1;
      applyStimulus(1'b1, 8'd10, 8'd5, 2'b00);
      tick();
      applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);
      checkOutput("addCountN", count, 1);
      checkOutput("addOutValidN", outValid, 0);
      tick();
      checkOutput("addAluA", aluA, 10);
      checkOutput("addAluB", aluB, 5);
      checkOutput("addCountN1", count, 0);
      checkOutput("addOutValidN1", outValid, 0);
      tick();
      checkOutput("addOutValidN2", outValid, 1);
      checkOutput("addOutResult", outResult, 15);
      checkOutput("addOutOpcode", outOpcode, 0);
      tick();
      checkOutput("addDrained", outValid, 0);
      checkOutput("addAluHold", aluA, 10);

      $display("[TB] back-to-back");
      for (int i = 0; i < 6; i++) begin
         if (i < 4)
            applyStimulus(1'b1, b2bA[i], b2bB[i], b2bOp[i]);
         else
            applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);
         tick();
         if (i >= 2) begin
            checkOutput($sformatf("b2bValid%0d", i - 2), outValid, 1);
            checkOutput($sformatf("b2bResult%0d", i - 2), outResult, b2bExp[i - 2]);
         end
      end
      tick();
      checkOutput("b2bDrained", outValid, 0);

      $display("[TB] backpressure");
      outReady = 1'b0;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (idx < 8)
            applyStimulus(1'b1, bpA[idx], bpB[idx], bpOp[idx]);
         else
            applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);
         accepted = inValid && inReady;
         tick();
         if (accepted)
            idx++;
      end
      applyStimulus(1'b1, bpA[idx], bpB[idx], bpOp[idx]);
      checkOutput("bpAccepted", idx, 6);
      checkOutput("bpCount", count, 4);
      checkOutput("bpInReady", inReady, 0);
      checkOutput("bpOutValid", outValid, 1);
      checkOutput("bpOutResult", outResult, 3);
      checkOutput("bpIssA", aluA, 9);
      checkOutput("bpIssOp", aluOpcode, 1);
      tick();
      tick();
      checkOutput("bpStableResult", outResult, 3);
      checkOutput("bpStableAluA", aluA, 9);
      checkOutput("bpStableCount", count, 4);

      $display("[TB] drain");
      outReady = 1'b1;
      nextOut  = 0;
      cyc      = 0;
      while (cyc < 40 && nextOut < 8) begin
         if (idx < 8)
            applyStimulus(1'b1, bpA[idx], bpB[idx], bpOp[idx]);
         else
            applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);
         if (cyc == 0)
            checkOutput("fullPopInReady", inReady, 0);
         accepted = inValid && inReady;
         fire     = outValid && outReady;
         if (fire) begin
            checkOutput($sformatf("drainResult%0d", nextOut), outResult, bpExp[nextOut]);
            checkOutput($sformatf("drainOpcode%0d", nextOut), outOpcode, bpOp[nextOut]);
         end
         tick();
         if (cyc == 0)
            checkOutput("fullPopCount", count, 3);
         if (accepted)
            idx++;
         if (fire)
            nextOut++;
         cyc++;
      end
      checkOutput("drainAllOut", nextOut, 8);
      checkOutput("drainAllIn", idx, 8);
      applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);
      tick();
      checkOutput("drainEmpty", outValid, 0);
      checkOutput("drainCount", count, 0);

      $display("[TB] reset mid-stream");
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, bpA[i], bpB[i], bpOp[i]);
         tick();
      end
      applyStimulus(1'b0, 8'd0, 8'd0, 2'b00);
      tick();
      checkOutput("preRstOutValid", outValid, 1);
      checkOutput("preRstAluA", aluA, 9);
      rst_n = 1'b0;
      #2;
      checkOutput("midRstOutValid", outValid, 0);
      checkOutput("midRstOutResult", outResult, 0);
      checkOutput("midRstOutOpcode", outOpcode, 0);
      checkOutput("midRstAluA", aluA, 0);
      checkOutput("midRstAluB", aluB, 0);
      checkOutput("midRstAluOp", aluOpcode, 0);
      checkOutput("midRstCount", count, 0);
      checkOutput("midRstInReady", inReady, 1);
      tick();
      rst_n    = 1'b1;
      outReady = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("postRstOutValid", outValid, 0);
      checkOutput("postRstCount", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream command front-end for the 8-bit combinational `alu`. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU's `a`/`b`/`opcode` ports, then registers the ALU `result` into an output stage with its own valid/ready handshake. It decouples a bursty command source from a stalling result consumer, and does so without adding a combinational path through the ALU to either handshake.

## Interface

- `DATA_W`, default 8: operand and result width; must match `alu`.
- `DEPTH`, default 4: command FIFO entries; power of two, ≥ 2.

- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous assert, active-low reset.
- `in_valid`, input, 1: command present.
- `in_ready`, output, 1: FIFO can accept.
  - Equals `count < DEPTH`.
  - Registered-state derived only; no combinational dependence on `out_ready`.
- `in_a`, input, `DATA_W`: operand a.
- `in_b`, input, `DATA_W`: operand b.
- `in_opcode`, input, 2: ALU opcode.
  - 00 = ADD, 01 = SUB.
  - 10 and 11 are passed through uninterpreted.
- `alu_a`, output, `DATA_W`: drives `alu.a`.
- `alu_b`, output, `DATA_W`: drives `alu.b`.
- `alu_opcode`, output, 2: drives `alu.opcode`.
- `alu_result`, input, `DATA_W`: from `alu.result`.
- `out_valid`, output, 1: result register holds unconsumed result.
- `out_ready`, input, 1: consumer accepts.
- `out_result`, output, `DATA_W`: captured ALU result.
- `out_opcode`, output, 2: opcode that produced `out_result`.
- `count`, output, `$clog2(DEPTH)+1`: FIFO occupancy; excludes the issue and output stages.

## Operation

- **Pipeline:** FIFO → issue register (ISS) → output register (OUT). ISS and OUT each carry a valid bit.
- **Push:** `in_valid && in_ready` writes `{in_opcode, in_a, in_b}` at the write pointer.
- **Pointers:** `$clog2(DEPTH)` bits each; wrap modulo `DEPTH`.
- **Issue advance:** ISS loads the FIFO head (pop) when the FIFO is non-empty and (ISS empty or ISS advancing).
- **Output capture:** OUT captures `{ISS.opcode, alu_result}` when ISS is valid and (OUT empty or `out_ready`).
  - ISS advances on the same edge.
- **ALU drive:** `alu_a`, `alu_b`, `alu_opcode` are driven directly from the ISS data registers.
  - ISS data loads only on pop.
  - When ISS is invalid, the last issued values are held; they are not zeroed.
- **Arithmetic:** performed entirely by `alu`. This block does not recompute or check results.
  - ADD/SUB wrap modulo 2^`DATA_W` (255+1 = 0, 0−1 = 255).
- **Output handshake:** OUT holds data stable while `out_valid && !out_ready`. A transfer occurs on `out_valid && out_ready`.
- **Simultaneous push and pop:** `count` unchanged.
  - Full FIFO: `in_ready` = 0 even if a pop occurs in the same cycle; no bypass.
- **Empty-FIFO path:** a pushed command is not visible to ISS until the following edge; there is no FIFO bypass.
- **Ordering:** strict command order is preserved end to end. No drops and no duplicates.

## Timing

- **Reset values** (asynchronous, while `rst_n` = 0):
  - `out_valid` = 0, `out_result` = 0, `out_opcode` = 0.
  - `alu_a` = `alu_b` = 0, `alu_opcode` = 0.
  - `count` = 0, `in_ready` = 1.
  - Pointers = 0; ISS and OUT valid bits = 0.
- **Reset mid-operation:** all buffered and in-flight commands are discarded. No output transfer occurs after reset assertion.
- **Latency:** command accepted at edge N with the pipeline empty:
  - popped into ISS at N+1;
  - `out_valid` = 1 after N+2.
  - Minimum latency is 2 cycles.
- **Throughput:** one command per cycle with `out_ready` held at 1.
- **Total capacity:** `DEPTH` + 2 commands (FIFO + ISS + OUT) before `in_ready` falls with `out_ready` = 0.
- **Stall:** when OUT is full and `out_ready` = 0, ISS holds and `alu_*` stay stable.
- **Drain:** after `out_ready` rises, the next result appears in the cycle following each OUT transfer.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-stream → all outputs at reset values immediately (before the next clock edge); `in_ready` = 1; no `out_valid` until new commands arrive.
- **Single ADD:** a=10, b=5, opcode=00 accepted at edge N → `alu_a`=10, `alu_b`=5 after N+1; `out_valid`=1, `out_result`=15, `out_opcode`=00 after N+2.
- **Back-to-back with `out_ready`=1:** 20−7, 10+5, 255+1, 0−1 → `out_result` 13, 15, 0, 255 on four consecutive cycles, starting at the third edge.
- **Backpressure, `out_ready`=0, 8 commands offered:** exactly 6 accepted; `count`=4; `in_ready`=0; `out_result` stable. Raise `out_ready` → all 6 results appear in order; remaining 2 accepted as space frees.
- **Full with simultaneous pop:** FIFO full, one output transfer → `in_ready` stays 0 that cycle; `count` = `DEPTH`−1 after the edge; no lost or duplicated command.
- **Opcodes 10 and 11:** passed through to `alu_opcode` and `out_opcode` unchanged; `out_result` equals `alu_result` sampled at the capture edge.
